display_bcd_driver: RTL and testbench
=====================================

// Module: display_bcd_driver
// PURPOSE
//  Downstream of the CPU OUT path: accepts a binary value on a load strobe and converts it
//  iteratively (shift-add-3, one bit per clock) to BCD. Registers five active-low 7-segment
//  codes for HEX5..HEX1. Supports leading-zero blanking, overflow indication and a blank request.
//  Replaces a purely combinational decoder chain, so HEX outputs change only on completed conversions.
// PARAMETERS
//  WIDTH        28  binary input width; conversion takes exactly WIDTH shift cycles
//  BLANK_ZEROS  1   1 = blank leading zero digits (HEX1 always shows a digit); 0 = show zeros
// PORTS
//  clock     in   1      system clock; all state on rising edge
//  reset_n   in   1      asynchronous, active-low reset
//  valor     in   WIDTH  binary value to display, sampled when carrega=1
//  apaga     in   1      sampled with carrega; 1 = result is all segments off
//  carrega   in   1      load strobe, one cycle per request
//  ocupado   out  1      1 while a conversion is in progress (CONV or FIM state)
//  pronto    out  1      one-cycle pulse when HEX outputs are updated
//  HEX5..HEX1 out 7 each active-low segments {g,f,e,d,c,b,a}; HEX5 = most significant digit
// BEHAVIOUR
//  Reset values: HEX5..HEX1=7'b1111111 (blank); ocupado=0; pronto=0; FSM=OCIOSO; pending flag cleared.
//  FSM states: OCIOSO -> CONV -> FIM -> OCIOSO (or -> CONV if pending).
//   OCIOSO: carrega=1 latches {apaga,valor}, clears BCD register, enters CONV.
//   CONV: each cycle shifts one input bit MSB-first into a BCD register of 4*ceil(WIDTH/3) bits.
//    Before each shift, every nibble >=5 gets +3.
//    After WIDTH cycles, moves to FIM.
//   FIM: HEX5..HEX1 registered, pronto=1 for this cycle.
//    If pending=1, the shadow value is loaded and the FSM goes to CONV; otherwise it goes to OCIOSO.
//  Latency: carrega at edge k -> HEX valid and pronto=1 after edge k+WIDTH+1 (29 clocks at WIDTH=28).
//  carrega while ocupado: {apaga,valor} goes to a shadow register and pending=1.
//   Later loads overwrite the shadow (latest wins); intermediate loads are discarded, never queued.
//  carrega in the same cycle as FIM: treated as pending; conversion restarts immediately.
//  Overflow: a value needing more than 5 digits gives HEX5..HEX2=SEG_MINUS, HEX1=SEG_E.
//  apaga=1 latched: all HEX blank at FIM. This takes priority over overflow and digits.
//  Blanking: with BLANK_ZEROS=1, zeros above the most significant nonzero digit are SEG_BLANK.
//   A value of 0 shows HEX1='0'.
//  Reset mid-conversion: immediate asynchronous return to reset values. The in-flight value is lost.
// CONFIGURATION
//  DISPLAY_SIGNED_EN defined:
//   valor is two's complement. If negative, the magnitude is converted.
//   HEX5=SEG_MINUS; magnitude range 0..9999 uses HEX4..HEX1; larger magnitude -> overflow pattern.
//   Negative values with leading-zero blanking still show SEG_MINUS in HEX5.
//   Conversion still takes WIDTH cycles; the magnitude is taken at load time.
//  DISPLAY_SIGNED_EN undefined: valor is unsigned; range 0..99999; no minus sign except in overflow.
// STRUCTURE
//  Shared package display_pkg:
//   SEG_BLANK=7'b1111111, SEG_MINUS=7'b0111111, SEG_E=7'b0000110;
//   FSM state encoding (OCIOSO, CONV, FIM); bcd_digits(width) function.
//  Sub-module decodificador_7seg: combinational 4-bit BCD -> 7-bit active-low segments.
//   Instantiated 5x, outputs registered here.
//  Shift/add-3 datapath, bit counter, shadow register and FSM stay in this module.
// TESTING
//  1 Assert reset_n=0 -> all HEX=7'b1111111, ocupado=0, pronto=0; hold 5 cycles with carrega=1 -> no change.
//  2 valor=12345, carrega 1 cycle -> ocupado=1 for 29 clocks.
//    HEX5..HEX1 = 7'b1111001,0100100,0110000,0011001,0010010.
//    pronto high for exactly 1 cycle.
//  3 valor=7, BLANK_ZEROS=1 -> HEX5..HEX2=SEG_BLANK, HEX1=7'b1111000; valor=0 -> HEX1=7'b1000000.
//  4 valor=100000 -> HEX5..HEX2=SEG_MINUS, HEX1=SEG_E.
//    Then valor=99999 with apaga=1 -> all SEG_BLANK.
//  5 Load 42, then 99 at +5 and 5 at +10 -> 42 is shown at +29, then 5 at +58.
//    pronto pulses exactly twice; 99 is never displayed.
//  6 reset_n low at cycle 15 of a conversion -> outputs blank asynchronously.
//    Next load of 8 completes normally.
//    With DISPLAY_SIGNED_EN, valor=-3 gives HEX5=SEG_MINUS, HEX1=7'b0110000.

Source files
------------

// File: rtl/display_bcd_driver_pkg.sv
// ============================================================================
// Module : display_pkg
// Brief  : Shared segment codes, FSM state encoding and BCD sizing helper
//          for the display_bcd_driver block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CONV   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    // Each decimal digit needs just over 3 binary bits, so ceil(width/3) digits always suffice
    function automatic int bcd_digits(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_bcd_driver_if.sv
// ============================================================================
// Module : display_bcd_driver_if
// Brief  : Load/status/segment bundle between the CPU OUT path and the driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface display_bcd_driver_if #(
    parameter int WIDTH = 28
);
    logic [WIDTH-1:0] valor;
    logic             apaga;
    logic             carrega;
    logic             ocupado;
    logic             pronto;
    logic [6:0]       HEX5;
    logic [6:0]       HEX4;
    logic [6:0]       HEX3;
    logic [6:0]       HEX2;
    logic [6:0]       HEX1;

    modport master (
        output valor, apaga, carrega,
        input  ocupado, pronto, HEX5, HEX4, HEX3, HEX2, HEX1
    );

    modport slave (
        input  valor, apaga, carrega,
        output ocupado, pronto, HEX5, HEX4, HEX3, HEX2, HEX1
    );
endinterface

`default_nettype wire

// File: rtl/display_bcd_driver_decodificador_7seg.sv
// ============================================================================
// Module : decodificador_7seg
// Brief  : Combinational BCD digit to active-low {g,f,e,d,c,b,a} segments.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decodificador_7seg (
    input  wire logic [3:0] i_bcd,
    output logic      [6:0] o_seg
);
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = 7'b1000000;
            4'd1:    o_seg = 7'b1111001;
            4'd2:    o_seg = 7'b0100100;
            4'd3:    o_seg = 7'b0110000;
            4'd4:    o_seg = 7'b0011001;
            4'd5:    o_seg = 7'b0010010;
            4'd6:    o_seg = 7'b0000010;
            4'd7:    o_seg = 7'b1111000;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0010000;
            default: o_seg = 7'b1111111;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/display_bcd_driver.sv
// ============================================================================
// Module : display_bcd_driver
// Brief  : Iterative shift-add-3 binary to BCD converter driving HEX5..HEX1,
//          with leading-zero blanking, overflow pattern and blank request.
//          Optional macro DISPLAY_SIGNED_EN: treat valor as two's complement.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module display_bcd_driver
    import display_pkg::*;
#(
    parameter int WIDTH       = 28,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input wire logic             clock,
    input wire logic             reset_n,
    display_bcd_driver_if.slave  bus
);

    localparam int NDIG  = bcd_digits(WIDTH);
    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    estado_t          r_estado;
    logic [WIDTH-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_apaga;
    logic             r_neg;
    logic             r_pend;
    logic             r_sh_apaga;
    logic             r_sh_neg;
    logic [WIDTH-1:0] r_sh_mag;
    logic             r_ocupado;
    logic             r_pronto;
    logic [6:0]       r_hex [5];

    logic             w_in_neg;
    logic [WIDTH-1:0] w_in_mag;
    logic             w_ld_apaga;
    logic             w_ld_neg;
    logic [WIDTH-1:0] w_ld_mag;
    logic [BCD_W-1:0] w_bcd_adj;
    logic [6:0]       w_seg [5];
    logic [6:0]       w_hex [5];
    logic [19:0]      w_low5;
    logic [4:1]       w_zero_from;
    logic             w_high_nz;
    logic             w_ovf;

    // Magnitude is resolved at load time so the converter itself is always unsigned
`ifdef DISPLAY_SIGNED_EN
    assign w_in_neg = bus.valor[WIDTH-1];
    assign w_in_mag = w_in_neg ? (~bus.valor + WIDTH'(1)) : bus.valor;
`else
    assign w_in_neg = 1'b0;
    assign w_in_mag = bus.valor;
`endif

    // In FIM a fresh strobe beats the shadow (latest wins); otherwise the shadow is used
    always_comb begin
        w_ld_apaga = bus.apaga;
        w_ld_neg   = w_in_neg;
        w_ld_mag   = w_in_mag;
        if (r_estado == FIM && !bus.carrega) begin
            w_ld_apaga = r_sh_apaga;
            w_ld_neg   = r_sh_neg;
            w_ld_mag   = r_sh_mag;
        end
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_dec
        decodificador_7seg u_dec (
            .i_bcd (r_bcd[4*gi +: 4]),
            .o_seg (w_seg[gi])
        );
    end

    if (NDIG > 5) begin : g_high
        assign w_high_nz = |r_bcd[BCD_W-1:20];
    end else begin : g_no_high
        assign w_high_nz = 1'b0;
    end

    assign w_low5 = r_bcd[19:0];
    // A negative value gives up HEX5 to the sign, so only four digits remain
    assign w_ovf  = w_high_nz | (r_neg & (r_bcd[19:16] != 4'd0));

    always_comb begin
        for (int i = 1; i < 5; i++) begin
            w_zero_from[i] = ((w_low5 >> (4 * i)) == 20'd0);
        end
    end

    always_comb begin
        w_hex[0] = w_seg[0];
        for (int i = 1; i < 5; i++) begin
            w_hex[i] = (BLANK_ZEROS && w_zero_from[i]) ? SEG_BLANK : w_seg[i];
        end
        if (r_neg) begin
            w_hex[4] = SEG_MINUS;
        end
        if (w_ovf) begin
            for (int i = 1; i < 5; i++) begin
                w_hex[i] = SEG_MINUS;
            end
            w_hex[0] = SEG_E;
        end
        if (r_apaga) begin
            for (int i = 0; i < 5; i++) begin
                w_hex[i] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado   <= OCIOSO;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_apaga    <= 1'b0;
            r_neg      <= 1'b0;
            r_pend     <= 1'b0;
            r_sh_apaga <= 1'b0;
            r_sh_neg   <= 1'b0;
            r_sh_mag   <= '0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_hex[i] <= SEG_BLANK;
            end
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (bus.carrega) begin
                        r_apaga   <= w_ld_apaga;
                        r_neg     <= w_ld_neg;
                        r_bin     <= w_ld_mag;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_ocupado <= 1'b1;
                        r_estado  <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[WIDTH-1]};
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_estado <= FIM;
                    end
                    if (bus.carrega) begin
                        r_sh_apaga <= w_in_neg ? bus.apaga : bus.apaga;
                        r_sh_neg   <= w_in_neg;
                        r_sh_mag   <= w_in_mag;
                        r_pend     <= 1'b1;
                    end
                end
                FIM: begin
                    for (int i = 0; i < 5; i++) begin
                        r_hex[i] <= w_hex[i];
                    end
                    r_pronto <= 1'b1;
                    if (bus.carrega || r_pend) begin
                        r_apaga  <= w_ld_apaga;
                        r_neg    <= w_ld_neg;
                        r_bin    <= w_ld_mag;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_pend   <= 1'b0;
                        r_estado <= CONV;
                    end else begin
                        r_ocupado <= 1'b0;
                        r_estado  <= OCIOSO;
                    end
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ocupado = r_ocupado;
    assign bus.pronto  = r_pronto;
    assign bus.HEX1    = r_hex[0];
    assign bus.HEX2    = r_hex[1];
    assign bus.HEX3    = r_hex[2];
    assign bus.HEX4    = r_hex[3];
    assign bus.HEX5    = r_hex[4];

endmodule

`default_nettype wire

// File: tb/tb_display_bcd_driver.sv
// ============================================================================
// Module : tb_display_bcd_driver
// Brief  : Directed self-checking bench for display_bcd_driver (WIDTH=28).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_display_bcd_driver;
    import display_pkg::*;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] MI = 7'b0111111;
    localparam logic [6:0] EE = 7'b0000110;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    display_bcd_driver_if #(.WIDTH(28)) bus ();

    display_bcd_driver #(.WIDTH(28), .BLANK_ZEROS(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic [34:0] hex_all;
    assign hex_all = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [27:0] v, input logic a);
        bus.valor   = v;
        bus.apaga   = a;
        bus.carrega = 1'b1;
        step();
        bus.carrega = 1'b0;
    endtask

    // Counts edges from the load edge until pronto; ocupado cycles counted alongside
    task automatic wait_done(output int lat, output int n_oc);
        lat  = 0;
        n_oc = bus.ocupado ? 1 : 0;
        while (lat < 100) begin
            step();
            lat++;
            if (bus.pronto) break;
            if (bus.ocupado) n_oc++;
        end
    endtask

    task automatic run_value(input string name, input logic [27:0] v, input logic a,
                             input logic [34:0] exp_hex);
        int lat, n_oc;
        load(v, a);
        wait_done(lat, n_oc);
        n_total++;
        if (lat !== 29) $display("FAIL %s latency: got %0d expected 29", name, lat);
        else n_pass++;
        n_total++;
        if (hex_all !== exp_hex) $display("FAIL %s hex: got %h expected %h", name, hex_all, exp_hex);
        else n_pass++;
        step();
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.valor   = 28'd12345;
        bus.apaga   = 1'b0;
        bus.carrega = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++;
            if ({hex_all, bus.ocupado, bus.pronto} !== {{5{BL}}, 1'b0, 1'b0})
                $display("FAIL reset_hold[%0d]: got %h/%b/%b expected all blank/0/0",
                         i, hex_all, bus.ocupado, bus.pronto);
            else n_pass++;
        end
        bus.carrega = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_digits();
        int lat, n_oc;
        load(28'd12345, 1'b0);
        wait_done(lat, n_oc);
        n_total++;
        if (n_oc !== 29) $display("FAIL ocupado_len: got %0d expected 29", n_oc);
        else n_pass++;
        n_total++;
        if (lat !== 29) $display("FAIL latency_12345: got %0d expected 29", lat);
        else n_pass++;
        n_total++;
        if (hex_all !== {D1, D2, D3, D4, D5})
            $display("FAIL hex_12345: got %h expected %h", hex_all, {D1, D2, D3, D4, D5});
        else n_pass++;
        n_total++;
        if (bus.ocupado !== 1'b0) $display("FAIL ocupado_end: got %b expected 0", bus.ocupado);
        else n_pass++;
        step();
        n_total++;
        if (bus.pronto !== 1'b0) $display("FAIL pronto_width: got %b expected 0", bus.pronto);
        else n_pass++;
    endtask

    task automatic test_blanking();
        run_value("val7", 28'd7, 1'b0, {BL, BL, BL, BL, D7});
        run_value("val0", 28'd0, 1'b0, {BL, BL, BL, BL, D0});
        run_value("val1005", 28'd1005, 1'b0, {BL, D1, D0, D0, D5});
    endtask

    task automatic test_overflow();
        run_value("ovf100000", 28'd100000, 1'b0, {MI, MI, MI, MI, EE});
        run_value("max99999", 28'd99999, 1'b0, {D9, D9, D9, D9, D9});
        run_value("apaga99999", 28'd99999, 1'b1, {BL, BL, BL, BL, BL});
        run_value("ovf_apaga", 28'd100000, 1'b1, {BL, BL, BL, BL, BL});
    endtask

    task automatic test_back_to_back();
        int e;
        int npulse;
        int pe [2];
        logic [34:0] ph [2];
        logic oc_mid;
        npulse = 0;
        oc_mid = 1'b0;
        load(28'd42, 1'b0);
        e = 0;
        repeat (4) begin step(); e++; end
        bus.valor = 28'd99; bus.carrega = 1'b1;
        step(); e++;
        bus.carrega = 1'b0;
        repeat (4) begin step(); e++; end
        bus.valor = 28'd5; bus.carrega = 1'b1;
        step(); e++;
        bus.carrega = 1'b0;
        while (e < 90) begin
            step(); e++;
            if (bus.pronto) begin
                if (npulse < 2) begin
                    pe[npulse] = e;
                    ph[npulse] = hex_all;
                    if (npulse == 0) oc_mid = bus.ocupado;
                end
                npulse++;
            end
        end
        n_total++;
        if (npulse !== 2) $display("FAIL b2b_pulses: got %0d expected 2", npulse);
        else n_pass++;
        if (npulse >= 1) begin
            n_total++;
            if (pe[0] !== 29) $display("FAIL b2b_first_time: got %0d expected 29", pe[0]);
            else n_pass++;
            n_total++;
            if (ph[0] !== {BL, BL, BL, D4, D2})
                $display("FAIL b2b_first_hex: got %h expected %h", ph[0], {BL, BL, BL, D4, D2});
            else n_pass++;
            n_total++;
            if (oc_mid !== 1'b1) $display("FAIL b2b_ocupado: got %b expected 1", oc_mid);
            else n_pass++;
        end
        if (npulse >= 2) begin
            n_total++;
            if (pe[1] !== 58) $display("FAIL b2b_second_time: got %0d expected 58", pe[1]);
            else n_pass++;
            n_total++;
            if (ph[1] !== {BL, BL, BL, BL, D5})
                $display("FAIL b2b_second_hex: got %h expected %h", ph[1], {BL, BL, BL, BL, D5});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        load(28'd12345, 1'b0);
        repeat (15) step();
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({hex_all, bus.ocupado, bus.pronto} !== {{5{BL}}, 1'b0, 1'b0})
            $display("FAIL reset_mid: got %h/%b/%b expected all blank/0/0",
                     hex_all, bus.ocupado, bus.pronto);
        else n_pass++;
        step();
        reset_n = 1'b1;
        step();
        run_value("after_reset8", 28'd8, 1'b0, {BL, BL, BL, BL, D8});
    endtask

`ifdef DISPLAY_SIGNED_EN
    task automatic test_signed();
        run_value("neg3", -28'sd3, 1'b0, {MI, BL, BL, BL, D3});
        run_value("neg10000", -28'sd10000, 1'b0, {MI, MI, MI, MI, EE});
    endtask
`endif

    initial begin
        bus.valor   = '0;
        bus.apaga   = 1'b0;
        bus.carrega = 1'b0;
        test_reset();
        test_digits();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
`ifdef DISPLAY_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
